// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: single write port into a register bank, shared by three requesters
// (0=ALU, 1=LOAD, 2=IO). After reset a four-step init sequence preloads r1, r2, r30 and
// r31, then the block arbitrates requests and forwards one write per cycle with a
// one-cycle registered latency. Writes to r0 are accepted but never strobed.
//
// Optional feature: define RR_ARB_EN for round-robin arbitration; otherwise fixed
// priority ALU > LOAD > IO and no pointer register is built.
//
// Ports:
//   clock                  rising-edge clock
//   reset_n                asynchronous active-low reset
//   req_valid[2:0]         per-requester write request
//   req_addr0..2           per-requester destination register
//   req_data0..2           per-requester write data
//   req_ready[2:0]         per-requester grant (combinational)
//   WriteEnable            register-bank write strobe
//   WriteReg               register-bank write address
//   WriteData              register-bank write data
//   init_done              high once the init sequence has been issued
module reg_write_arbiter #(
  parameter logic [31:0] INIT_R1  = 32'd0,
  parameter logic [31:0] INIT_R2  = 32'd1,
  parameter logic [31:0] INIT_R30 = 32'd126,
  parameter logic [31:0] INIT_R31 = 32'd127
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  req_valid,
  input  logic [4:0]  req_addr0,
  input  logic [4:0]  req_addr1,
  input  logic [4:0]  req_addr2,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  input  logic [31:0] req_data2,
  output logic [2:0]  req_ready,
  output logic        WriteEnable,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic        init_done
);

  typedef enum logic {StInit = 1'b0, StArb = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        we_q, we_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;

  logic [2:0]  grant;
  logic        xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic [4:0]  init_addr;
  logic [31:0] init_data;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef RR_ARB_EN
  // ptr_q holds the last granted requester; the search starts one past it.
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    grant = 3'b000;
    case (ptr_q)
      2'd0: begin
        if      (req_valid[1]) grant = 3'b010;
        else if (req_valid[2]) grant = 3'b100;
        else if (req_valid[0]) grant = 3'b001;
      end
      2'd1: begin
        if      (req_valid[2]) grant = 3'b100;
        else if (req_valid[0]) grant = 3'b001;
        else if (req_valid[1]) grant = 3'b010;
      end
      default: begin
        if      (req_valid[0]) grant = 3'b001;
        else if (req_valid[1]) grant = 3'b010;
        else if (req_valid[2]) grant = 3'b100;
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if      (req_ready[0]) ptr_d = 2'd0;
      else if (req_ready[1]) ptr_d = 2'd1;
      else                   ptr_d = 2'd2;
    end
  end

  // Reset to 2 so the first search after reset starts at the ALU.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 2'd2;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    grant = 3'b000;
    if      (req_valid[0]) grant = 3'b001;
    else if (req_valid[1]) grant = 3'b010;
    else if (req_valid[2]) grant = 3'b100;
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInit;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == StInit) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        state_d = StArb;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and write-port next values
  // ---------------------------------------------------------------------------
  always_comb begin
    case (idx_q)
      2'd0:    begin init_addr = 5'd1;  init_data = INIT_R1;  end
      2'd1:    begin init_addr = 5'd2;  init_data = INIT_R2;  end
      2'd2:    begin init_addr = 5'd30; init_data = INIT_R30; end
      default: begin init_addr = 5'd31; init_data = INIT_R31; end
    endcase
  end

  always_comb begin
    req_ready = (state_q == StArb) ? grant : 3'b000;
    xfer      = |(req_valid & req_ready);

    sel_addr = req_addr0;
    sel_data = req_data0;
    if (req_ready[1]) begin
      sel_addr = req_addr1;
      sel_data = req_data1;
    end else if (req_ready[2]) begin
      sel_addr = req_addr2;
      sel_data = req_data2;
    end

    // Address/data hold their last value unless a real write is issued.
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    if (state_q == StInit) begin
      we_d    = 1'b1;
      wreg_d  = init_addr;
      wdata_d = init_data;
      if (idx_q == 2'd3) begin
        done_d = 1'b1;
      end
    end else if (xfer && (sel_addr != 5'd0)) begin
      we_d    = 1'b1;
      wreg_d  = sel_addr;
      wdata_d = sel_data;
    end
  end

  // Write-port registers; reset also discards any transfer accepted in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      wreg_q  <= 5'd0;
      wdata_q <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign WriteEnable = we_q;
  assign WriteReg    = wreg_q;
  assign WriteData   = wdata_q;
  assign init_done   = done_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [4:0]  addr_a [3];
  logic [31:0] data_a [3];
  logic [2:0]  req_ready;
  logic        WriteEnable;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_addr0   (addr_a[0]),
    .req_addr1   (addr_a[1]),
    .req_addr2   (addr_a[2]),
    .req_data0   (data_a[0]),
    .req_data1   (data_a[1]),
    .req_data2   (data_a[2]),
    .req_ready   (req_ready),
    .WriteEnable (WriteEnable),
    .WriteReg    (WriteReg),
    .WriteData   (WriteData),
    .init_done   (init_done)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of pending init writes, then a grant search by
  // requester order starting after the last winner.
  // ---------------------------------------------------------------------------
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t         init_q [$];
  int          last_gnt;
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic        m_done;

  task automatic model_reset();
    init_q.delete();
    init_q.push_back({5'd1,  32'd0});
    init_q.push_back({5'd2,  32'd1});
    init_q.push_back({5'd30, 32'd126});
    init_q.push_back({5'd31, 32'd127});
    last_gnt = 2;
    m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0; m_done = 1'b0;
  endtask

  function automatic logic [2:0] model_ready();
    if (init_q.size() != 0) return 3'b000;
`ifdef RR_ARB_EN
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last_gnt + k) % 3;
      if (req_valid[i]) return 3'(1 << i);
    end
`else
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i]) return 3'(1 << i);
    end
`endif
    return 3'b000;
  endfunction

  task automatic model_edge(input logic [2:0] g);
    wr_t w;
    if (init_q.size() != 0) begin
      w = init_q.pop_front();
      m_we = 1'b1; m_reg = w.a; m_data = w.d;
      if (init_q.size() == 0) m_done = 1'b1;
    end else begin
      m_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (g[i]) begin
          last_gnt = i;
          if (addr_a[i] != 5'd0) begin
            m_we = 1'b1; m_reg = addr_a[i]; m_data = data_a[i];
          end
        end
      end
    end
  endtask

  task automatic cycle_model(output logic [2:0] g);
    #1;
    g = model_ready();
    check("rand_ready", req_ready, g);
    @(posedge clock);
    model_edge(g);
    @(negedge clock);
    check("rand_we", WriteEnable, m_we);
    check("rand_done", init_done, m_done);
    if (m_we) begin
      check("rand_reg", WriteReg, m_reg);
      check("rand_data", WriteData, m_data);
    end
  endtask

  // Called at a negedge; releases reset at the following negedge.
  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = 3'b000;
    #1;
    check("rst_we", WriteEnable, 1'b0);
    check("rst_reg", WriteReg, 5'd0);
    check("rst_data", WriteData, 32'd0);
    check("rst_done", init_done, 1'b0);
    check("rst_ready", req_ready, 3'b000);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic check_init_seq();
    logic [4:0]  er [4];
    logic [31:0] ed [4];
    er = '{5'd1, 5'd2, 5'd30, 5'd31};
    ed = '{32'd0, 32'd1, 32'd126, 32'd127};
    for (int k = 0; k < 4; k++) begin
      #1;
      check("init_ready", req_ready, 3'b000);
      tick();
      check("init_we", WriteEnable, 1'b1);
      check("init_reg", WriteReg, er[k]);
      check("init_data", WriteData, ed[k]);
      check("init_done", init_done, (k == 3) ? 32'd1 : 32'd0);
    end
  endtask

  typedef struct packed {
    logic [2:0]  valid;
    logic [4:0]  a;
    logic [31:0] d;
    logic [2:0]  exp_rdy;
    logic        exp_we;
  } vec_t;

  initial begin
    vec_t        tbl [8];
    logic [2:0]  g;
    logic [4:0]  a34 [3];
    logic [31:0] d34 [3];

    for (int i = 0; i < 3; i++) begin
      addr_a[i] = 5'd0;
      data_a[i] = 32'd0;
    end
    @(negedge clock);

    // Reset release with no requests: four init writes, then idle.
    do_reset();
    check_init_seq();
    tick();
    check("idle_we", WriteEnable, 1'b0);
    check("idle_done", init_done, 1'b1);

    // Request raised during INIT waits for ARB, then is written one cycle later.
    do_reset();
    req_valid = 3'b001; addr_a[0] = 5'd5; data_a[0] = 32'hA5;
    check_init_seq();
    #1;
    check("held_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    check("held_we", WriteEnable, 1'b1);
    check("held_reg", WriteReg, 5'd5);
    check("held_data", WriteData, 32'hA5);

    // Table of single-requester vectors in ARB.
    tbl[0] = '{3'b001, 5'd7,  32'h1111_1111, 3'b001, 1'b1};
    tbl[1] = '{3'b010, 5'd9,  32'hDEAD_BEEF, 3'b010, 1'b1};
    tbl[2] = '{3'b100, 5'd31, 32'h1234_5678, 3'b100, 1'b1};
    tbl[3] = '{3'b000, 5'd12, 32'h0,         3'b000, 1'b0};
    tbl[4] = '{3'b010, 5'd0,  32'hFFFF_FFFF, 3'b010, 1'b0};
    tbl[5] = '{3'b100, 5'd0,  32'h5,         3'b100, 1'b0};
    tbl[6] = '{3'b001, 5'd1,  32'h8000_0000, 3'b001, 1'b1};
    tbl[7] = '{3'b100, 5'd17, 32'h0BAD_F00D, 3'b100, 1'b1};
    for (int v = 0; v < 8; v++) begin
      req_valid = tbl[v].valid;
      for (int i = 0; i < 3; i++) begin
        addr_a[i] = tbl[v].valid[i] ? tbl[v].a : 5'($urandom);
        data_a[i] = tbl[v].valid[i] ? tbl[v].d : $urandom;
      end
      #1;
      check("tbl_ready", req_ready, tbl[v].exp_rdy);
      tick();
      check("tbl_we", WriteEnable, tbl[v].exp_we);
      if (tbl[v].exp_we) begin
        check("tbl_reg", WriteReg, tbl[v].a);
        check("tbl_data", WriteData, tbl[v].d);
      end
    end
    req_valid = 3'b000;

    // All three requesting continuously from a fresh reset.
    do_reset();
    check_init_seq();
    a34 = '{5'd3, 5'd4, 5'd6};
    d34 = '{32'h30, 32'h40, 32'h60};
    for (int i = 0; i < 3; i++) begin
      addr_a[i] = a34[i];
      data_a[i] = d34[i];
    end
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      int w;
`ifdef RR_ARB_EN
      w = c % 3;
`else
      w = 0;
`endif
      #1;
      check("all_ready", req_ready, 32'(1 << w));
      tick();
      check("all_we", WriteEnable, 1'b1);
      check("all_reg", WriteReg, a34[w]);
      check("all_data", WriteData, d34[w]);
    end
    req_valid = 3'b000;

    // LOAD write to r0: accepted, never strobed.
    req_valid = 3'b010; addr_a[1] = 5'd0; data_a[1] = 32'hFFFF_FFFF;
    #1;
    check("r0_ready", req_ready, 3'b010);
    tick();
    req_valid = 3'b000;
    check("r0_we", WriteEnable, 1'b0);
    #1;
    check("r0_ready_off", req_ready, 3'b000);
    tick();
    check("r0_we2", WriteEnable, 1'b0);

    // Reset mid-INIT at index 2, then mid-transfer.
    do_reset();
    tick();
    tick();
    check("mid_init_reg", WriteReg, 5'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_init_we", WriteEnable, 1'b0);
    check("mid_init_reg0", WriteReg, 5'd0);
    check("mid_init_data0", WriteData, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    check_init_seq();
    req_valid = 3'b100; addr_a[2] = 5'd17; data_a[2] = 32'hCAFE;
    #1;
    check("mid_xfer_ready", req_ready, 3'b100);
    tick();
    check("mid_xfer_we", WriteEnable, 1'b1);
    check("mid_xfer_reg", WriteReg, 5'd17);
    req_valid = 3'b111;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_xfer_we0", WriteEnable, 1'b0);
    check("mid_xfer_reg0", WriteReg, 5'd0);
    check("mid_xfer_data0", WriteData, 32'd0);
    check("mid_xfer_done0", init_done, 1'b0);
    check("mid_xfer_ready0", req_ready, 3'b000);
    req_valid = 3'b000;
    @(negedge clock);
    reset_n = 1'b1;
    check_init_seq();

    // Randomized traffic against the model; requests hold until granted.
    @(negedge clock);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          addr_a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
          data_a[i] = $urandom;
        end
      end
      cycle_model(g);
      for (int i = 0; i < 3; i++) begin
        if (g[i]) req_valid[i] = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
